// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcode codes, FSM state type,
// and helpers for opcode legality and per-op latency.
package alu_seq_pkg;

  localparam logic [3:0] OP_PASSB = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_RSVD  = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_DIV   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_SRA   = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Legal codes are 0000, 0001 and 0011..1011; 0010 and 1100..1111 are not.
  function automatic logic op_legal(input logic [3:0] op);
    return (op != OP_RSVD) && (op <= OP_SRA);
  endfunction

  // Number of cycles the ALU inputs are held for a given op.
  function automatic logic [3:0] op_lat(input logic [3:0] op,
                                        input int        mul_lat,
                                        input int        div_lat,
                                        input int        base_lat);
    logic [3:0] lat;
    case (op)
      OP_MUL:  lat = 4'(mul_lat);
      OP_DIV:  lat = 4'(div_lat);
      default: lat = 4'(base_lat);
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/alu_sequencer_arb.sv
// Two-way round-robin grant. The pointer names the requester that wins a
// tie; it moves to the requester that was not served when advance_i fires.
module alu_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic advance_i,
  input  logic served_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic ptr_q;
  logic ptr_d;

  // Next pointer: after a completed op, favour the other requester.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = ~served_i;
    end
  end

  // Pointer register, reset to favour requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt0_o = valid0_i & (~valid1_i | ~ptr_q);
  assign gnt1_o = valid1_i & (~valid0_i |  ptr_q);

endmodule

// File: rtl/alu_sequencer.sv
// Shares one external 32-bit ALU between two requesters with round-robin
// arbitration, holds ALU inputs for the op latency, and returns the result
// on a tagged response channel.
// Optional feature macro: ALU_FLAGS_EN adds a {N, Z, C} flags output.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. reqN_ready is combinational and never depends on reqN_op/a/b.
// rsp_valid, once high, stays high with rsp_* unchanged until rsp_ready.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 8,
  parameter int BASE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [3:0]  alu_s,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_y,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_err,
  output state_t      dbg_state_o
`ifdef ALU_FLAGS_EN
  ,
  output logic [2:0]  flags
`endif
);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  alu_s_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_data_q;
  logic        rsp_carry_q;
  logic        rsp_err_q;
`ifdef ALU_FLAGS_EN
  logic [2:0]  flags_q;
`endif

  logic        gnt0;
  logic        gnt1;
  logic        accept;
  logic        rsp_hs;
  logic        sel_id;
  logic [3:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_err;

  alu_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid0_i  (req0_valid),
    .valid1_i  (req1_valid),
    .advance_i (rsp_hs),
    .served_i  (rsp_id_q),
    .gnt0_o    (gnt0),
    .gnt1_o    (gnt1)
  );

  // Grants already imply valid, so either ready means a handshake.
  assign req0_ready = (state_q == IDLE) && gnt0;
  assign req1_ready = (state_q == IDLE) && gnt1;
  assign accept     = req0_ready || req1_ready;
  assign rsp_hs     = (state_q == RESP) && rsp_ready;

  assign sel_id  = gnt1;
  assign sel_op  = gnt1 ? req1_op : req0_op;
  assign sel_a   = gnt1 ? req1_a  : req0_a;
  assign sel_b   = gnt1 ? req1_b  : req0_b;
  assign sel_err = !op_legal(sel_op) || ((sel_op == OP_DIV) && (sel_b == 32'h0));

  // Sequencer FSM: accept one op, hold the ALU inputs for its latency,
  // then present the captured result until it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'h0;
      alu_s_q     <= 4'h0;
      alu_a_q     <= 32'h0;
      alu_b_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef ALU_FLAGS_EN
      flags_q     <= 3'b000;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rsp_id_q <= sel_id;
            if (sel_err) begin
              // Errors skip the ALU entirely.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 32'h0;
              rsp_carry_q <= 1'b0;
            end else begin
              state_q <= EXEC;
              cnt_q   <= op_lat(sel_op, MUL_LAT, DIV_LAT, BASE_LAT) - 4'd1;
              alu_s_q <= sel_op;
              alu_a_q <= sel_a;
              alu_b_q <= sel_b;
            end
          end
        end
        EXEC: begin
          if (cnt_q == 4'h0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= alu_y;
            rsp_carry_q <= alu_carry;
            alu_s_q     <= 4'h0;
            alu_a_q     <= 32'h0;
            alu_b_q     <= 32'h0;
`ifdef ALU_FLAGS_EN
            flags_q     <= {alu_y[31], (alu_y == 32'h0), alu_carry};
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_s       = alu_s_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_carry   = rsp_carry_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state_o = state_q;
`ifdef ALU_FLAGS_EN
  assign flags       = flags_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios followed by random traffic,
// all checked against a transaction-level model of arbitration, latency
// and results. An ALU model drives alu_y/alu_carry.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int MUL_LAT  = 3;
  localparam int DIV_LAT  = 8;
  localparam int BASE_LAT = 1;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  alu_s;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        alu_carry;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
  logic [31:0] rsp_data;
  state_t      dbg_state;
`ifdef ALU_FLAGS_EN
  logic [2:0]  flags;
  logic [2:0]  flags_m;
`endif

  always #5 clk = ~clk;

  alu_sequencer #(
    .MUL_LAT  (MUL_LAT),
    .DIV_LAT  (DIV_LAT),
    .BASE_LAT (BASE_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .alu_s       (alu_s),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_y       (alu_y),
    .alu_carry   (alu_carry),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_carry   (rsp_carry),
    .rsp_err     (rsp_err),
    .dbg_state_o (dbg_state)
`ifdef ALU_FLAGS_EN
    ,
    .flags       (flags)
`endif
  );

  // ---------------- ALU model (the external ALU) ----------------
  function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0: return {1'b0, b};
      4'h1: return {1'b0, a} + {1'b0, b};
      4'h3: return {1'b0, a * b};
      4'h4: return {1'b0, (b == 32'h0) ? 32'h0 : a / b};
      4'h5: return {1'b0, a - b};
      4'h6: return {1'b0, a & b};
      4'h7: return {1'b0, a | b};
      4'h8: return {1'b0, a ^ b};
      4'h9: return {1'b0, a << b[4:0]};
      4'hA: return {1'b0, a >> b[4:0]};
      4'hB: return {1'b0, 32'($signed(a) >>> b[4:0])};
      default: return 33'h0;
    endcase
  endfunction

  always_comb begin
    {alu_carry, alu_y} = alu_fn(alu_s, alu_a, alu_b);
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // Expected response {id, err, carry, data}; at most one op is in flight.
  logic [34:0] exp_q[$];
  int          acc_log[$];
  bit          mon_en = 1'b0;
  bit          busy   = 1'b0;
  bit          rr     = 1'b0;
  int          cyc    = 0;
  int          acc_cyc, due, cur_lat;
  logic        cur_err, cur_id;
  logic [3:0]  cur_op;
  logic [31:0] cur_a, cur_b;

  always @(negedge clk) begin : mon
    logic        g0, g1, in_exec, err;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [32:0] r;
    if (!rst_n) begin
      busy = 1'b0;
      rr   = 1'b0;
      exp_q.delete();
`ifdef ALU_FLAGS_EN
      flags_m = 3'b000;
`endif
    end else if (mon_en) begin
      cyc++;
      g0 = !busy && req0_valid && (!req1_valid || !rr);
      g1 = !busy && req1_valid && (!req0_valid ||  rr);
      check_eq("req0_ready", 64'(req0_ready), 64'(g0));
      check_eq("req1_ready", 64'(req1_ready), 64'(g1));

      in_exec = busy && !cur_err && (cyc > acc_cyc) && (cyc <= acc_cyc + cur_lat);
      check_eq("alu_s", 64'(alu_s), in_exec ? 64'(cur_op) : 64'h0);
      check_eq("alu_a", 64'(alu_a), in_exec ? 64'(cur_a)  : 64'h0);
      check_eq("alu_b", 64'(alu_b), in_exec ? 64'(cur_b)  : 64'h0);

`ifdef ALU_FLAGS_EN
      if (busy && !cur_err && cyc == due)
        flags_m = {exp_q[0][31], (exp_q[0][31:0] == 32'h0), exp_q[0][32]};
      check_eq("flags", 64'(flags), 64'(flags_m));
`endif

      check_eq("rsp_valid", 64'(rsp_valid), 64'(busy && cyc >= due));
      if (rsp_valid && exp_q.size() > 0)
        check_eq("rsp_fields", 64'({rsp_id, rsp_err, rsp_carry, rsp_data}), 64'(exp_q[0]));

      if (busy && cyc >= due && rsp_ready) begin
        void'(exp_q.pop_front());
        busy = 1'b0;
        rr   = !cur_id;
      end else if (g0 || g1) begin
        op  = g1 ? req1_op : req0_op;
        a   = g1 ? req1_a  : req0_a;
        b   = g1 ? req1_b  : req0_b;
        err = !(op inside {4'h0, 4'h1, [4'h3:4'hB]}) || (op == 4'h4 && b == 32'h0);
        r   = err ? 33'h0 : alu_fn(op, a, b);
        exp_q.push_back({g1, err, r});
        acc_log.push_back(int'(g1));
        cur_id  = g1;
        cur_err = err;
        cur_op  = op;
        cur_a   = a;
        cur_b   = b;
        cur_lat = (op == 4'h3) ? MUL_LAT : (op == 4'h4) ? DIV_LAT : BASE_LAT;
        acc_cyc = cyc;
        due     = cyc + (err ? 1 : cur_lat + 1);
        busy    = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge.
  task automatic issue(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit got = 1'b0;
    if (id == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else         begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((id == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (!got) check_eq("issue_timeout", 64'(got), 64'h1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    if (busy) check_eq("wait_idle_timeout", 64'(busy), 64'h0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
    check_eq({tag, "_rsp_err"},   64'(rsp_err),   64'h0);
    check_eq({tag, "_alu_s"},     64'(alu_s),     64'h0);
    check_eq({tag, "_alu_a"},     64'(alu_a),     64'h0);
    check_eq({tag, "_alu_b"},     64'(alu_b),     64'h0);
    check_eq({tag, "_state"},     64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_ids[4] = '{0, 1, 0, 1};
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = 4'h0; req0_a = 32'h0; req0_b = 32'h0;
    req1_valid = 1'b0; req1_op = 4'h0; req1_a = 32'h0; req1_b = 32'h0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    check_eq("reset_rsp_data",  64'(rsp_data),  64'h0);
    check_eq("reset_rsp_carry", 64'(rsp_carry), 64'h0);
    check_eq("reset_rsp_id",    64'(rsp_id),    64'h0);
    check_eq("reset_req0_ready", 64'(req0_ready), 64'h0);
    check_eq("reset_req1_ready", 64'(req1_ready), 64'h0);

    // Both requesters valid from reset with op 0101: grants must alternate.
    req0_valid = 1'b1; req0_op = 4'h5; req0_a = $urandom; req0_b = $urandom;
    req1_valid = 1'b1; req1_op = 4'h5; req1_a = $urandom; req1_b = $urandom;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (acc_log.size() >= 4) break;
    end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("rr_accept_count", 64'(acc_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      check_eq("rr_order", 64'(acc_log[i]), 64'(exp_ids[i]));
    wait_idle();

    // Add with carry out: FFFFFFFF + 1.
    issue(0, 4'h1, 32'hFFFF_FFFF, 32'h1);
    wait_idle();

    // Divide by zero from requester 1: error response, ALU untouched.
    issue(1, 4'h4, 32'd100, 32'd0);
    wait_idle();

    // Illegal opcodes.
    issue(0, 4'h2, 32'h1234, 32'h5678);
    wait_idle();
    issue(1, 4'hE, 32'h1, 32'h2);
    wait_idle();

    // Multiply 7*6 with the multi-cycle latency.
    issue(0, 4'h3, 32'd7, 32'd6);
    wait_idle();

    // Back-pressure: response held for 5 cycles while req1 waits.
    rsp_ready = 1'b0;
    issue(0, 4'h1, 32'h10, 32'h20);
    req1_valid = 1'b1; req1_op = 4'h7; req1_a = 32'hF0; req1_b = 32'h0F;
    for (int k = 0; k < 50; k++) begin
      if (rsp_valid) break;
      @(posedge clk); #1;
    end
    check_eq("bp_rsp_valid", 64'(rsp_valid), 64'h1);
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("bp_req1_after_hs", 64'(req1_ready), 64'h1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a divide.
    issue(0, 4'h4, 32'd1000, 32'd7);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midop_reset");
    req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'h1; req0_b = 32'hAB;
    req1_valid = 1'b1; req1_op = 4'h0; req1_a = 32'h2; req1_b = 32'hCD;
    @(posedge clk); #1;
    acc_log.delete();
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      if (acc_log.size() >= 1) break;
    end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("post_reset_count", 64'(acc_log.size()), 64'd1);
    if (acc_log.size() >= 1)
      check_eq("post_reset_grant", 64'(acc_log[0]), 64'd0);
    wait_idle();

    // Random traffic: valids may drop without a handshake.
    for (int i = 0; i < 1500; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req0_op    = 4'($urandom_range(0, 15));
      req0_a     = $urandom;
      req0_b     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      req1_valid = 1'($urandom_range(0, 1));
      req1_op    = 4'($urandom_range(0, 15));
      req1_a     = $urandom;
      req1_b     = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 40));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
